// File: rtl/gate_input_debouncer_pkg.sv
// Shared definitions for the input-facing gate blocks: debouncer state
// encoding and default conditioning parameters.
package gates_pkg;

    typedef enum logic [0:0] {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } debounce_state_t;

    localparam int GATES_SYNC_STAGES     = 2;
    localparam int GATES_DEBOUNCE_CYCLES = 16;

endpackage : gates_pkg

// File: rtl/gate_input_debouncer_if.sv
// Signal bundle between the raw input source and the debounced consumer.
// The master drives the raw level; the slave (the debouncer) returns the clean level and pulses.
interface gate_input_debouncer_if;

    logic A;
    logic Y;
    logic rise;
    logic fall;
    logic stable;

    modport master (
        output A,
        input  Y,
        input  rise,
        input  fall,
        input  stable
    );

    modport slave (
        input  A,
        output Y,
        output rise,
        output fall,
        output stable
    );

endinterface : gate_input_debouncer_if

// File: rtl/sync_chain.sv
// Reusable multi-flop synchroniser for asynchronous single-bit inputs.
// All stages clear to 0 on asynchronous reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_q;

    // Shift the raw level through the synchroniser stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= {STAGES{1'b0}};
        end else begin
            r_q <= {r_q[STAGES-2:0], d};
        end
    end

    assign q = r_q[STAGES-1];

endmodule : sync_chain

// File: rtl/gate_input_debouncer.sv
// Synchronises and debounces a raw input level, producing a registered clean
// level plus one-cycle rise/fall pulses for the downstream buffer gate.
module gate_input_debouncer
    import gates_pkg::*;
#(
    parameter int SYNC_STAGES     = GATES_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GATES_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gate_input_debouncer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            w_a_sync;
    debounce_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_y;
    logic            r_rise;
    logic            r_fall;
    logic            r_stable;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.A),
        .q     (w_a_sync)
    );

    // Debounce FSM: candidate level must persist DEBOUNCE_CYCLES samples to be accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= STABLE;
            r_cnt    <= CNT_ZERO;
            r_y      <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_stable <= 1'b1;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE: begin
                    if (w_a_sync != r_y) begin
                        r_state  <= CHECK;
                        r_cnt    <= CNT_ONE;
                        r_stable <= 1'b0;
                    end else begin
                        r_cnt    <= CNT_ZERO;
                        r_stable <= 1'b1;
                    end
                end
                CHECK: begin
                    if (w_a_sync == r_y) begin
                        r_state  <= STABLE;
                        r_cnt    <= CNT_ZERO;
                        r_stable <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        // Pulse polarity follows the level being left
                        r_y      <= ~r_y;
                        r_rise   <= ~r_y;
                        r_fall   <= r_y;
                        r_state  <= STABLE;
                        r_cnt    <= CNT_ZERO;
                        r_stable <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + CNT_ONE;
                        r_stable <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= STABLE;
                    r_cnt    <= CNT_ZERO;
                    r_stable <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Y      = r_y;
    assign bus.rise   = r_rise;
    assign bus.fall   = r_fall;
    assign bus.stable = r_stable;

endmodule : gate_input_debouncer

// File: doc/gate_input_debouncer.md
# gate_input_debouncer

Single-bit input conditioner that sits directly upstream of the buffer gate and drives its `A` input. It synchronises a raw asynchronous level (switch, pin, external strobe) into the `clk` domain, filters glitches with a saturating stability counter, and presents a clean registered level plus one-cycle rise/fall pulses. Every downstream gate therefore sees only debounced, glitch-free transitions.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count; legal range 2..4.
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronised samples required to accept a new level; legal range 2..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width; derived, never overridden.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `A`  in  1  raw asynchronous input level.
- `Y`  out  1  debounced level (registered); feeds the buffer gate `A`.
- `rise`  out  1  one-cycle pulse, high in the cycle `Y` goes 0→1.
- `fall`  out  1  one-cycle pulse, high in the cycle `Y` goes 1→0.
- `stable`  out  1  high when the FSM is in STABLE (no candidate pending).

## Operation
- Synchroniser: `A` passes through `SYNC_STAGES` flops; the last stage is `a_sync`. No other logic touches raw `A`.
- FSM states:
  - STABLE: `a_sync == Y`, `cnt == 0`. On `a_sync != Y`, go to CHECK with `cnt <= 1`.
  - CHECK: candidate is `~Y`.
    - If `a_sync == Y` (glitch), return to STABLE with `cnt <= 0`; `Y` is unchanged and no pulse is issued.
    - Else if `cnt == DEBOUNCE_CYCLES-1`, set `Y <= ~Y`, pulse `rise` or `fall`, return to STABLE, `cnt <= 0`.
    - Else `cnt <= cnt + 1`.
- Counter: unsigned `CNT_W` bits, never exceeds `DEBOUNCE_CYCLES-1`, no wrap.
- `rise`/`fall`: registered, mutually exclusive, never high two consecutive cycles.
- `stable`: decoded from the state register, registered.
- Reset (async assert, at any time including mid-CHECK):
  - sync flops 0, `Y = 0`, `rise = 0`, `fall = 0`;
  - state STABLE, `cnt = 0`, `stable = 1`.
  - Any pending candidate is discarded.
- Release of `rst_n` is assumed synchronised externally. The first active edge after release behaves as a normal edge.
- If `A` is high at reset release, it is debounced normally and produces one `rise`.

## Timing
- Edge 0 is the first rising edge that samples the new `A` value. `a_sync` shows the new value after edge `SYNC_STAGES-1`.
- Acceptance latency: `Y`, `rise` and `fall` update at edge `SYNC_STAGES + DEBOUNCE_CYCLES - 1`. Defaults: edge 17. With `DEBOUNCE_CYCLES = 4` and `SYNC_STAGES = 2`: edge 5.
- Pulse width: exactly 1 clk.
- `stable` drops on the edge CHECK is entered and rises on the same edge `Y` toggles or the glitch abort occurs.
- Minimum accepted pulse width on `A`: `DEBOUNCE_CYCLES` clk periods, plus synchroniser uncertainty of 1 clk.
- Back-to-back transitions: after an acceptance, a new opposite-level candidate can enter CHECK on the very next edge. The minimum spacing of `rise` → `fall` is `DEBOUNCE_CYCLES` edges.
- Combinational paths from input to output: none.

## Structure
- Shared package `gates_pkg`:
  - `debounce_state_t` enum {STABLE, CHECK};
  - localparam defaults `GATES_SYNC_STAGES = 2` and `GATES_DEBOUNCE_CYCLES = 16`.
- Sub-module `sync_chain`:
  - parameter `STAGES`;
  - ports `clk`, `rst_n`, `d`, `q`;
  - async-reset-to-0 flop chain.
- It is instantiated once here and is reusable by other input-facing gates.
- Top level holds the FSM, counter and output registers only.

## Test plan
(All scenarios use `DEBOUNCE_CYCLES = 4`, `SYNC_STAGES = 2`, clk period 10 ns.)
- Reset check: hold `rst_n = 0` with `A` toggling → `Y = 0`, `rise = 0`, `fall = 0`, `stable = 1` throughout. Release `rst_n` with `A = 0` for 20 cycles → no pulses.
- Clean rise: `A` 0→1 held before edge 0 → `Y = 1` and `rise = 1` at edge 5. `rise` is low at edge 6. `stable` is low from edge 2 through edge 4.
- Glitch reject: `A` high for 3 cycles, then low → `Y` stays 0 and no `rise`. `stable` returns high and `cnt` returns to 0.
- Clean fall after rise: with `Y = 1`, `A` 1→0 → `fall = 1` for exactly one cycle at edge 5 after sampling, and `Y = 0`.
- Reset mid-operation: assert `rst_n = 0` while in CHECK with `cnt = 2` → `Y`, `cnt` and the pulses clear immediately (asynchronously). After release, with `A` still 1 → `rise` occurs 5 edges later.
- Chatter: `A` toggles every 2 cycles for 40 cycles, then holds at 1 → exactly one `rise` and zero `fall`. `Y = 1` five edges after the final toggle is sampled.
